// File: rtl/pixel_mem_arbiter_pkg.sv
// Shared definitions for the pixel/scanout memory arbiter.
// Holds the FSM state encoding, the default framebuffer geometry and the
// starvation limit used by the arbiter top level.
package pixel_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_VGA_RD  = 3'd1,
        S_RMW_RD  = 3'd2,
        S_RMW_MOD = 3'd3,
        S_RMW_WR  = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    localparam int DEF_FB_Y0          = 80;
    localparam int DEF_FB_W           = 640;
    localparam int DEF_FB_H           = 400;
    localparam int DEF_STARVE_LIMIT   = 8;
    localparam int FB_WORDS_PER_LINE  = DEF_FB_W / 16;

endpackage

// File: rtl/pixel_mem_arbiter_addr_map.sv
// pixel_addr_map: combinational pixel coordinate -> framebuffer word mapping.
// Ports:
//   x, y      in   11  pixel column / row (screen coordinates)
//   word      out  16  RAM word address holding the pixel
//   bit_idx   out  4   bit within the word (15 = leftmost pixel)
//   in_range  out  1   coordinate lies inside the framebuffer
module pixel_addr_map #(
    parameter int FB_Y0 = 80,
    parameter int FB_W  = 640,
    parameter int FB_H  = 400
) (
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic [15:0] word,
    output logic [3:0]  bit_idx,
    output logic        in_range
);
    localparam logic [15:0] WPL    = 16'(FB_W / 16);
    localparam logic [11:0] X_END  = 12'(FB_W);
    localparam logic [11:0] Y_LO   = 12'(FB_Y0);
    localparam logic [11:0] Y_END  = 12'(FB_Y0 + FB_H);

    logic [15:0] row;

    // Out-of-range rows wrap here; the result is ignored in that case.
    assign row      = {5'b0, y} - 16'(FB_Y0);
    assign word     = row * WPL + {9'b0, x[10:4]};
    assign bit_idx  = 4'd15 - x[3:0];
    assign in_range = ({1'b0, x} < X_END) && ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_END);

endmodule

// File: rtl/pixel_mem_arbiter.sv
// pixel_mem_arbiter: shares one single-port framebuffer RAM between VGA
// scanout reads and single-pixel read-modify-write updates.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   vga_req/vga_addr/vga_gnt         scanout read request / address / accept
//   vga_valid/vga_rdata              scanout read data (one cycle after grant)
//   px_req/px_x/px_y/px_val/px_ack   pixel set/clear request and accept
//   px_done/px_err                   pixel completion pulse / out-of-range flag
//   mem_addr/mem_we/mem_wdata        RAM command
//   mem_rdata                        RAM read data, one-cycle latency
// Optional feature: define PIXEL_READBACK_EN to add px_old, the prior pixel
// value, valid with px_done (0 on error).
module pixel_mem_arbiter
    import pixel_mem_arbiter_pkg::*;
#(
    parameter int FB_Y0        = DEF_FB_Y0,
    parameter int FB_W         = DEF_FB_W,
    parameter int FB_H         = DEF_FB_H,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vga_req,
    input  logic [15:0] vga_addr,
    output logic        vga_gnt,
    output logic        vga_valid,
    output logic [15:0] vga_rdata,
    input  logic        px_req,
    input  logic [10:0] px_x,
    input  logic [10:0] px_y,
    input  logic        px_val,
    output logic        px_ack,
    output logic        px_done,
    output logic        px_err,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
`ifdef PIXEL_READBACK_EN
    ,
    output logic        px_old
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    state_t      state, state_next;
    logic [SW-1:0] starve;
    logic [15:0] addr_q;
    logic [15:0] word_q;
    logic [3:0]  bit_q;
    logic        val_q;
    logic [15:0] data_q;
    logic [15:0] map_word;
    logic [3:0]  map_bit;
    logic        map_in_range;
    logic [15:0] mask;

    pixel_addr_map #(.FB_Y0(FB_Y0), .FB_W(FB_W), .FB_H(FB_H)) u_map (
        .x        (px_x),
        .y        (px_y),
        .word     (map_word),
        .bit_idx  (map_bit),
        .in_range (map_in_range)
    );

    assign mask = 16'h0001 << bit_q;

    always_comb begin
        state_next = state;
        vga_gnt    = 1'b0;
        vga_valid  = 1'b0;
        vga_rdata  = 16'h0000;
        px_ack     = 1'b0;
        px_done    = 1'b0;
        px_err     = 1'b0;
        mem_addr   = addr_q;
        mem_we     = 1'b0;
        mem_wdata  = 16'h0000;
        case (state)
            S_IDLE: begin
                // Scanout normally wins; a saturated starvation count hands
                // the slot to the waiting pixel request.
                if (px_req && (!vga_req || starve == LIMIT)) begin
                    px_ack     = 1'b1;
                    state_next = map_in_range ? S_RMW_RD : S_ERR;
                end else if (vga_req) begin
                    vga_gnt    = 1'b1;
                    mem_addr   = vga_addr;
                    state_next = S_VGA_RD;
                end
            end
            S_VGA_RD: begin
                vga_valid  = 1'b1;
                vga_rdata  = mem_rdata;
                state_next = S_IDLE;
            end
            S_RMW_RD: begin
                mem_addr   = word_q;
                state_next = S_RMW_MOD;
            end
            S_RMW_MOD: begin
                state_next = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_addr   = word_q;
                mem_we     = 1'b1;
                mem_wdata  = data_q;
                px_done    = 1'b1;
                state_next = S_IDLE;
            end
            S_ERR: begin
                px_done    = 1'b1;
                px_err     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef PIXEL_READBACK_EN
    logic old_q;
    assign px_old = (state == S_RMW_WR) ? old_q : 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            starve <= '0;
            addr_q <= 16'h0000;
            word_q <= 16'h0000;
            bit_q  <= 4'h0;
            val_q  <= 1'b0;
            data_q <= 16'h0000;
`ifdef PIXEL_READBACK_EN
            old_q  <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            // Remember whatever address was presented so it holds when idle.
            addr_q <= mem_addr;
            if (!px_req || px_ack)
                starve <= '0;
            else if (vga_gnt && starve != LIMIT)
                starve <= starve + 1'b1;
            if (px_ack) begin
                word_q <= map_word;
                bit_q  <= map_bit;
                val_q  <= px_val;
            end
            if (state == S_RMW_MOD) begin
                data_q <= val_q ? (mem_rdata | mask) : (mem_rdata & ~mask);
`ifdef PIXEL_READBACK_EN
                old_q  <= mem_rdata[bit_q];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
module tb_pixel_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_gnt;
    logic        vga_valid;
    logic [15:0] vga_rdata;
    logic        px_req;
    logic [10:0] px_x;
    logic [10:0] px_y;
    logic        px_val;
    logic        px_ack;
    logic        px_done;
    logic        px_err;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef PIXEL_READBACK_EN
    logic        px_old;
    logic        last_old;
`endif

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [15:0] ram [0:65535];

    pixel_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_gnt   (vga_gnt),
        .vga_valid (vga_valid),
        .vga_rdata (vga_rdata),
        .px_req    (px_req),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_val    (px_val),
        .px_ack    (px_ack),
        .px_done   (px_done),
        .px_err    (px_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef PIXEL_READBACK_EN
        ,
        .px_old    (px_old)
`endif
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we === 1'b1) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one pixel request. lat counts cycles with the ack cycle as 1,
    // so lat is the cycle in which px_done was seen.
    task automatic pixel_op(input logic [10:0] x, input logic [10:0] y, input logic v,
                            output int lat, output logic err,
                            output logic [15:0] wa, output logic [15:0] wd, output int wes);
        int n;
        int we0;
        we0 = we_cnt;
        @(negedge clk);
        px_req = 1'b1; px_x = x; px_y = y; px_val = v;
        #1;
        n = 0;
        while (px_ack !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        lat = 1;
        @(negedge clk);
        px_req = 1'b0;
        #1;
        lat = 2;
        while (px_done !== 1'b1 && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        err = px_err;
        wa  = mem_addr;
        wd  = mem_wdata;
`ifdef PIXEL_READBACK_EN
        last_old = px_old;
`endif
        @(negedge clk); #1;
        wes = we_cnt - we0;
    endtask

    int          lat;
    logic        err;
    logic [15:0] wa;
    logic [15:0] wd;
    int          wes;
    int          n;
    int          grants;
    int          gnt_during;
    int          we_snap;

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        ram[1]     = 16'hFFFF;
        ram[5]     = 16'h1234;
        ram[41]    = 16'h0001;
        ram[15999] = 16'hFFFF;

        rst_n = 1'b0;
        vga_req = 1'b0; vga_addr = 16'h0000;
        px_req = 1'b0; px_x = 11'd0; px_y = 11'd0; px_val = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {15'd0, vga_gnt, vga_valid, vga_rdata, px_ack, px_done, px_err, mem_we}, 32'd0);
        chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Set leftmost pixel of the first framebuffer line.
        pixel_op(11'd0, 11'd80, 1'b1, lat, err, wa, wd, wes);
        chk("set00_latency", lat, 4);
        chk("set00_err", {31'd0, err}, 32'd0);
        chk("set00_addr", {16'd0, wa}, 32'd0);
        chk("set00_data", {16'd0, wd}, 32'h8000);
        chk("set00_writes", wes, 1);
        chk("set00_ram", {16'd0, ram[0]}, 32'h8000);
`ifdef PIXEL_READBACK_EN
        chk("set00_old", {31'd0, last_old}, 32'd0);
`endif

        // Clear bottom-right pixel.
        pixel_op(11'd639, 11'd479, 1'b0, lat, err, wa, wd, wes);
        chk("clr_br_err", {31'd0, err}, 32'd0);
        chk("clr_br_addr", {16'd0, wa}, 32'd15999);
        chk("clr_br_data", {16'd0, wd}, 32'hFFFE);
        chk("clr_br_ram", {16'd0, ram[15999]}, 32'hFFFE);
`ifdef PIXEL_READBACK_EN
        chk("clr_br_old", {31'd0, last_old}, 32'd1);
`endif

        // Out-of-range coordinates.
        pixel_op(11'd640, 11'd80, 1'b1, lat, err, wa, wd, wes);
        chk("x640_err", {31'd0, err}, 32'd1);
        chk("x640_latency", lat, 2);
        chk("x640_writes", wes, 0);
`ifdef PIXEL_READBACK_EN
        chk("x640_old", {31'd0, last_old}, 32'd0);
`endif
        pixel_op(11'd0, 11'd79, 1'b1, lat, err, wa, wd, wes);
        chk("y79_err", {31'd0, err}, 32'd1);
        chk("y79_writes", wes, 0);
        pixel_op(11'd5, 11'd480, 1'b0, lat, err, wa, wd, wes);
        chk("y480_err", {31'd0, err}, 32'd1);
        chk("y480_writes", wes, 0);

        // Simultaneous requests: scanout first, then the pixel.
        @(negedge clk);
        vga_req = 1'b1; vga_addr = 16'd5;
        px_req = 1'b1; px_x = 11'd16; px_y = 11'd81; px_val = 1'b1;
        #1;
        chk("tie_vga_gnt", {31'd0, vga_gnt}, 32'd1);
        chk("tie_px_ack_held", {31'd0, px_ack}, 32'd0);
        chk("tie_vga_addr", {16'd0, mem_addr}, 32'd5);
        @(negedge clk);
        vga_req = 1'b0;
        #1;
        chk("tie_vga_valid", {31'd0, vga_valid}, 32'd1);
        chk("tie_vga_rdata", {16'd0, vga_rdata}, 32'h1234);
        @(negedge clk); #1;
        chk("tie_px_ack", {31'd0, px_ack}, 32'd1);
        @(negedge clk);
        px_req = 1'b0;
        #1;
        n = 0;
        while (px_done !== 1'b1 && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk("tie_px_addr", {16'd0, mem_addr}, 32'd41);
        chk("tie_px_data", {16'd0, mem_wdata}, 32'h8001);

        // Continuous scanout pressure: pixel slips in after the limit.
        @(negedge clk);
        vga_req = 1'b1; vga_addr = 16'd7;
        px_req = 1'b1; px_x = 11'd32; px_y = 11'd82; px_val = 1'b1;
        grants = 0;
        n = 0;
        #1;
        while (px_ack !== 1'b1 && n < 60) begin
            if (vga_gnt === 1'b1) grants++;
            @(negedge clk); #1; n++;
        end
        chk("starve_ack", {31'd0, px_ack}, 32'd1);
        chk("starve_grants", grants, 8);
        @(negedge clk);
        px_req = 1'b0;
        #1;
        gnt_during = 0;
        n = 0;
        while (px_done !== 1'b1 && n < 10) begin
            if (vga_gnt === 1'b1) gnt_during++;
            @(negedge clk); #1; n++;
        end
        chk("starve_px_data", {16'd0, mem_wdata}, 32'h8000);
        chk("starve_no_vga_in_rmw", gnt_during, 0);
        @(negedge clk); #1;
        chk("starve_vga_resume", {31'd0, vga_gnt}, 32'd1);
        chk("starve_vga_addr", {16'd0, mem_addr}, 32'd7);
        @(negedge clk);
        vga_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a read-modify-write.
        @(negedge clk);
        px_req = 1'b1; px_x = 11'd16; px_y = 11'd80; px_val = 1'b0;
        #1;
        chk("rst_px_ack", {31'd0, px_ack}, 32'd1);
        @(negedge clk);
        px_req = 1'b0;
        @(negedge clk);
        #1;
        we_snap = we_cnt;
        chk("rst_mod_no_we", {31'd0, mem_we}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", {15'd0, vga_gnt, vga_valid, vga_rdata, px_ack, px_done, px_err, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vga_req = 1'b1; vga_addr = 16'd9;
        #1;
        chk("rst_idle_gnt", {31'd0, vga_gnt}, 32'd1);
        @(negedge clk);
        vga_req = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_no_write", we_cnt - we_snap, 0);
        chk("rst_ram_intact", {16'd0, ram[1]}, 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
